// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - handshake/bus bundle for the registered immediate generator
//
// Purpose: groups the upstream push side, the downstream pop side, the flush
// strobe and the error counter of imm_extend_pipe into one interface.
// Signals:
//   flush                  synchronous buffer clear (pipeline redirect)
//   in_valid / in_ready    upstream handshake (in_ready is a flop output)
//   instr, immsrc, in_tag  instruction word, format select, sideband
//   out_valid / out_ready  downstream handshake for the head entry
//   out_imm, out_tag       head entry immediate and sideband
//   out_illegal            head entry carried an illegal format select
//   err_cnt                saturating count of accepted illegal entries
// Modports: master = producer/consumer side, slave = the immediate generator.
interface imm_extend_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int ERR_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       immsrc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output flush, in_valid, instr, immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal, err_cnt
  );

  modport slave (
    input  flush, in_valid, instr, immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal, err_cnt
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered RISC-V immediate generator behind a 2-entry skid buffer
//
// Purpose: decodes the immediate of a 32-bit instruction (I/S/B/J/U formats),
// sign-extends it to XLEN bits at push time and queues it with its sideband tag
// in a 2-entry valid/ready buffer. Illegal format selects yield a zero
// immediate, set out_illegal and bump a saturating error counter.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of imm_extend_pipe_if (see that file for signal list)
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int ERR_W = 8
) (
  input logic               clk,
  input logic               rst,
  imm_extend_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             occ;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ERR_W-1:0] err_q;

  // Entry 0 is the head and drives the outputs directly; entry 1 is the skid slot.
  logic [XLEN-1:0]  head_imm, tail_imm;
  logic [TAG_W-1:0] head_tag, tail_tag;
  logic             head_ill, tail_ill;

  logic             push;
  logic             pop;
  logic             new_ill;
  logic [XLEN-1:0]  new_imm;

  // Every format is first built as a 32-bit sign-extended value, then widened
  // by a signed cast so XLEN=32 and XLEN=64 share one decode.
  function automatic logic [XLEN-1:0] extend(input logic [31:0] i, input logic [2:0] sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      3'd0:    v = {{20{i[31]}}, i[31:20]};
      3'd1:    v = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    v = {i[31:12], 12'b0};
      default: v = '0;
    endcase
    return XLEN'($signed(v));
  endfunction

  assign new_ill = (bus.immsrc > 3'd4);
  assign new_imm = extend(bus.instr, bus.immsrc);

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = head_imm;
  assign bus.out_tag     = head_tag;
  assign bus.out_illegal = head_ill;
  assign bus.err_cnt     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ         <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      head_imm    <= '0;
      head_tag    <= '0;
      head_ill    <= 1'b0;
      tail_imm    <= '0;
      tail_tag    <= '0;
      tail_ill    <= 1'b0;
    end else if (bus.flush) begin
      // Entry contents are left alone so the head outputs hold their last value.
      occ         <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (push && new_ill && (err_q != {ERR_W{1'b1}}))
        err_q <= err_q + ERR_W'(1);

      case (occ)
        EMPTY: begin
          if (push) begin
            head_imm    <= new_imm;
            head_tag    <= bus.in_tag;
            head_ill    <= new_ill;
            occ         <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail_imm   <= new_imm;
            tail_tag   <= bus.in_tag;
            tail_ill   <= new_ill;
            occ        <= FULL;
            in_ready_q <= 1'b0;
          end else if (push && pop) begin
            head_imm <= new_imm;
            head_tag <= bus.in_tag;
            head_ill <= new_ill;
          end else if (pop) begin
            occ         <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so the only possible event is a pop.
          if (pop) begin
            head_imm   <= tail_imm;
            head_tag   <= tail_tag;
            head_ill   <= tail_ill;
            occ        <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          occ         <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe (XLEN=64/ERR_W=2 and XLEN=32/ERR_W=8)
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush, in_valid, out_ready;
  logic [31:0] instr, in_tag;
  logic [2:0]  immsrc;

  imm_extend_pipe_if #(.XLEN(64), .TAG_W(32), .ERR_W(2)) b64 ();
  imm_extend_pipe_if #(.XLEN(32), .TAG_W(32), .ERR_W(8)) b32 ();

  assign b64.flush = flush;  assign b64.in_valid = in_valid; assign b64.instr = instr;
  assign b64.immsrc = immsrc; assign b64.in_tag = in_tag;    assign b64.out_ready = out_ready;
  assign b32.flush = flush;  assign b32.in_valid = in_valid; assign b32.instr = instr;
  assign b32.immsrc = immsrc; assign b32.in_tag = in_tag;    assign b32.out_ready = out_ready;

  imm_extend_pipe #(.XLEN(64), .TAG_W(32), .ERR_W(2)) u64 (.clk(clk), .rst(rst), .bus(b64));
  imm_extend_pipe #(.XLEN(32), .TAG_W(32), .ERR_W(8)) u32 (.clk(clk), .rst(rst), .bus(b32));

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two entries plus an unsaturated illegal count.
  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } ent_t;
  ent_t q[$];
  int   err_n = 0;

  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] sel);
    longint v;
    case (sel)
      3'd0:    v = longint'($signed(i[31:20]));
      3'd1:    v = longint'($signed({i[31:25], i[11:7]}));
      3'd2:    v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd3:    v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd4:    v = longint'($signed(i)) & ~longint'(64'hFFF);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Drive one cycle at the negedge and advance the model to the state after the next posedge.
  task automatic drive(input bit iv, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [31:0] tag, input bit ordy, input bit fl);
    bit can_in, p, pu;
    ent_t e;
    in_valid = iv; instr = ins; immsrc = sel; in_tag = tag; out_ready = ordy; flush = fl;
    can_in = (q.size() < 2);
    if (fl) begin
      q.delete();
    end else begin
      p  = ordy && (q.size() > 0);
      pu = iv && can_in;
      if (p) void'(q.pop_front());
      if (pu) begin
        e.imm = ref_imm(ins, sel);
        e.tag = tag;
        e.ill = (sel > 3'd4);
        q.push_back(e);
        if (e.ill) err_n++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 9) < 6, $urandom, 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 4);
  endtask

  // Single compare process: every cycle, 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    if (checking) begin
      chk("out_valid64", b64.out_valid, q.size() != 0);
      chk("out_valid32", b32.out_valid, q.size() != 0);
      chk("in_ready64", b64.in_ready, q.size() < 2);
      chk("in_ready32", b32.in_ready, q.size() < 2);
      chk("err_cnt64", b64.err_cnt, sat(err_n, 3));
      chk("err_cnt32", b32.err_cnt, sat(err_n, 255));
      if (q.size() != 0) begin
        chk("out_imm64", b64.out_imm, q[0].imm);
        chk("out_imm32", b32.out_imm, q[0].imm[31:0]);
        chk("out_tag64", b64.out_tag, q[0].tag);
        chk("out_tag32", b32.out_tag, q[0].tag);
        chk("out_illegal64", b64.out_illegal, q[0].ill);
        chk("out_illegal32", b32.out_illegal, q[0].ill);
      end else begin
        chk("no_x64", $isunknown({b64.out_imm, b64.out_tag, b64.out_illegal}), 0);
        chk("no_x32", $isunknown({b32.out_imm, b32.out_tag, b32.out_illegal}), 0);
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid64"}, b64.out_valid, 0);
    chk({tag, "_valid32"}, b32.out_valid, 0);
    chk({tag, "_imm64"}, b64.out_imm, 0);
    chk({tag, "_imm32"}, b32.out_imm, 0);
    chk({tag, "_tag64"}, b64.out_tag, 0);
    chk({tag, "_tag32"}, b32.out_tag, 0);
    chk({tag, "_ill64"}, b64.out_illegal, 0);
    chk({tag, "_err64"}, b64.err_cnt, 0);
    chk({tag, "_err32"}, b32.err_cnt, 0);
    chk({tag, "_rdy64"}, b64.in_ready, 1);
  endtask

  logic [31:0] vin  [7] = '{32'hFFF00093, 32'h00512423, 32'hFE000EE3, 32'h0010006F,
                            32'h12345037, 32'h80000037, 32'h12345678};
  logic [2:0]  vsel [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
  logic [63:0] vexp [7] = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h800,
                            64'h12345000, 64'hFFFFFFFF80000000, 64'h0};

  initial begin
    flush = 0; in_valid = 0; instr = 0; immsrc = 0; in_tag = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst = 0;
    checking = 1;
    @(negedge clk);

    // Pin the model itself to hand-computed values.
    for (int k = 0; k < 7; k++) chk("model_imm", ref_imm(vin[k], vsel[k]), vexp[k]);

    // Each vector through both DUTs, then popped.
    for (int k = 0; k < 7; k++) begin
      drive(1, vin[k], vsel[k], 32'(k + 1), 1, 0);
      chk("dir_valid", b64.out_valid, 1);
      chk("dir_imm64", b64.out_imm, vexp[k]);
      chk("dir_imm32", b32.out_imm, {32'h0, vexp[k][31:0]});
      chk("dir_tag", b64.out_tag, k + 1);
      drive(0, 0, 0, 0, 1, 0);
    end
    err_n = err_n;

    // Backpressure: tags 1,2,3 offered with out_ready low.
    drive(1, $urandom, 0, 1, 0, 0);
    drive(1, $urandom, 0, 2, 0, 0);
    chk("bp_in_ready_low", b64.in_ready, 0);
    chk("bp_head1", b64.out_tag, 1);
    drive(1, $urandom, 0, 3, 1, 0);
    chk("bp_head2", b64.out_tag, 2);
    chk("bp_in_ready_back", b64.in_ready, 1);
    drive(1, $urandom, 0, 3, 1, 0);
    chk("bp_head3", b64.out_tag, 3);
    drive(0, 0, 0, 0, 1, 0);
    chk("bp_drained", b64.out_valid, 0);

    // Illegal selects: counter saturates at 3 on the 2-bit instance.
    // One illegal vector already went through above, so the running count starts at 1.
    drive(1, $urandom, 5, 32'h100, 0, 0);
    chk("ill_flag", b64.out_illegal, 1);
    chk("ill_imm", b64.out_imm, 0);
    chk("ill_err64", b64.err_cnt, 2);
    repeat (4) drive(1, $urandom, 3'($urandom_range(5, 7)), 32'h101, 1, 0);
    chk("ill_sat64", b64.err_cnt, 3);
    chk("ill_cnt32", b32.err_cnt, 6);
    drive(0, 0, 0, 0, 1, 0);

    // Flush with two entries and a same-cycle illegal push.
    drive(1, $urandom, 1, 32'hA, 0, 0);
    drive(1, $urandom, 2, 32'hB, 0, 0);
    chk("fl_full", b64.in_ready, 0);
    drive(1, $urandom, 6, 32'hC, 0, 1);
    chk("fl_valid64", b64.out_valid, 0);
    chk("fl_valid32", b32.out_valid, 0);
    chk("fl_in_ready", b64.in_ready, 1);
    chk("fl_err_kept", b32.err_cnt, 6);

    repeat (1500) drive_rand();

    // Asynchronous reset in the middle of traffic.
    drive(1, $urandom, 0, 32'h55, 0, 0);
    drive(1, $urandom, 7, 32'h66, 0, 0);
    in_valid = 0;
    #2;
    rst = 1;
    q.delete();
    err_n = 0;
    #1;
    chk_reset_values("midrst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    repeat (500) drive_rand();

    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
